// File: rtl/rr_pipe_arbiter_pkg.sv
// Shared definitions for the round-robin pipe arbiter: default sizes, beat type,
// and the rotating-pointer wrap helper.
package rr_pipe_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 3;

  typedef logic [DEF_DATA_W-1:0] beat_t;

  // Pointer moves to the requester just after the one granted, wrapping to 0.
  function automatic int unsigned rr_wrap(int unsigned sel, int unsigned num_req);
    return (sel == num_req - 1) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/rr_pipe_arbiter_if.sv
// Upstream multi-requester and downstream single-slot valid/ready bundle.
// The slave modport is the arbiter; the master modport is its environment.
interface rr_pipe_arbiter_if #(
  parameter int unsigned NUM_REQ = rr_pipe_arbiter_pkg::DEF_NUM_REQ,
  parameter int unsigned DATA_W  = rr_pipe_arbiter_pkg::DEF_DATA_W
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        valid_up;
  logic [NUM_REQ*DATA_W-1:0] data_up;
  logic [NUM_REQ-1:0]        ready_up;
  logic                      valid_down;
  logic [DATA_W-1:0]         data_down;
  logic [ID_W-1:0]           src_id;
  logic                      ready_down;

  modport slave (
    input  valid_up, data_up, ready_down,
    output ready_up, valid_down, data_down, src_id
  );

  modport master (
    output valid_up, data_up, ready_down,
    input  ready_up, valid_down, data_down, src_id
  );

endinterface

// File: rtl/rr_pipe_arbiter_pick.sv
// Rotating priority encoder: first set bit of i_valid searching from i_ptr upward,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick
  import rr_pipe_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_sel,
  output logic               o_any
);

  always_comb begin
    int unsigned idx;
    o_sel = '0;
    o_any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_valid[ID_W'(idx)]) begin
        o_any = 1'b1;
        o_sel = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_pipe_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready slot between NUM_REQ masters.
// Slot refills in the same cycle it drains; ptr advances only on an upstream accept.
module rr_pipe_arbiter
  import rr_pipe_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input logic              sys_clk,
  input logic              rst_n,
  rr_pipe_arbiter_if.slave io_bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_src_id;
  logic [ID_W-1:0]   r_ptr;

  logic [ID_W-1:0]   w_sel;
  logic              w_any;
  logic              w_slot_free;
  logic              w_up_xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_valid (io_bus.valid_up),
    .i_ptr   (r_ptr),
    .o_sel   (w_sel),
    .o_any   (w_any)
  );

  assign w_slot_free = !r_valid || io_bus.ready_down;
  // rst_n gating keeps ready_up low while reset is held, even though the slot reads free.
  assign w_up_xfer   = rst_n && w_any && w_slot_free;

  always_comb begin
    io_bus.ready_up = '0;
    if (w_up_xfer) io_bus.ready_up[w_sel] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_src_id <= '0;
      r_ptr    <= '0;
    end else if (w_up_xfer) begin
      r_valid  <= 1'b1;
      r_data   <= io_bus.data_up[w_sel*DATA_W +: DATA_W];
      r_src_id <= w_sel;
      r_ptr    <= ID_W'(rr_wrap(32'(w_sel), NUM_REQ));
    end else if (io_bus.ready_down) begin
      r_valid  <= 1'b0;
    end
  end

  assign io_bus.valid_down = r_valid;
  assign io_bus.data_down  = r_data;
  assign io_bus.src_id     = r_src_id;

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Directed and scoreboard bench for rr_pipe_arbiter with NUM_REQ=4, DATA_W=3.
module tb_rr_pipe_arbiter;
  import rr_pipe_arbiter_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 3;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [DW-1:0] sbq [NR][$];

  rr_pipe_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  rr_pipe_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .io_bus  (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid_up = 4'hF;
    bus.data_up = {3'd7, 3'd7, 3'd7, 3'd7};
    bus.ready_down = 1'b0;
    #1;
    n_checks++;
    if ({bus.ready_up, bus.valid_down, bus.data_down, bus.src_id} !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_idle got ru=%b v=%b d=%0d s=%0d want all 0",
               bus.ready_up, bus.valid_down, bus.data_down, bus.src_id);
    end
    cycle();
    cycle();
    rst_n = 1'b1;
    bus.valid_up = 4'b0100;
    bus.data_up = {3'd7, 3'd5, 3'd7, 3'd7};
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0100) begin
      n_errors++;
      $display("FAIL reset_first_grant got ru=%b want 0100", bus.ready_up);
    end
    cycle();
    n_checks++;
    if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, 3'd5, 2'd2}) begin
      n_errors++;
      $display("FAIL reset_load got v=%b d=%0d s=%0d want v=1 d=5 s=2",
               bus.valid_down, bus.data_down, bus.src_id);
    end
    bus.valid_up = 4'b0000;
    cycle();
    // Slot is full and stalled, ptr=3: reset now must clear it at once.
    bus.valid_up = 4'hF;
    bus.data_up = {3'd4, 3'd3, 3'd2, 3'd1};
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.ready_up, bus.valid_down, bus.data_down, bus.src_id} !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_async got ru=%b v=%b d=%0d s=%0d want all 0",
               bus.ready_up, bus.valid_down, bus.data_down, bus.src_id);
    end
    cycle();
    rst_n = 1'b1;
    bus.ready_down = 1'b1;
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_ptr got ru=%b want 0001", bus.ready_up);
    end
    cycle();
    n_checks++;
    if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, 3'd1, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_regrant got v=%b d=%0d s=%0d want v=1 d=1 s=0",
               bus.valid_down, bus.data_down, bus.src_id);
    end
    bus.valid_up = 4'b0000;
    cycle();
    n_checks++;
    if (bus.valid_down !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_drain got v=%b want 0", bus.valid_down);
    end
  endtask

  task automatic test_single();
    bus.valid_up = 4'b0100;
    bus.data_up = {3'd7, 3'd5, 3'd7, 3'd7};
    bus.ready_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (bus.ready_up !== 4'b0100) begin
        n_errors++;
        $display("FAIL single_ready[%0d] got ru=%b want 0100", i, bus.ready_up);
      end
      cycle();
      n_checks++;
      if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, 3'd5, 2'd2}) begin
        n_errors++;
        $display("FAIL single_beat[%0d] got v=%b d=%0d s=%0d want v=1 d=5 s=2",
                 i, bus.valid_down, bus.data_down, bus.src_id);
      end
    end
    bus.valid_up = 4'b0000;
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_idle_ready got ru=%b want 0000", bus.ready_up);
    end
    cycle();
    n_checks++;
    if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b0, 3'd5, 2'd2}) begin
      n_errors++;
      $display("FAIL single_drain got v=%b d=%0d s=%0d want v=0 d=5 s=2",
               bus.valid_down, bus.data_down, bus.src_id);
    end
  endtask

  task automatic test_all_valid();
    int exp_src [6] = '{0, 1, 2, 3, 0, 1};
    logic [1:0] es;
    logic [2:0] ed;
    // ptr is 3 here; one beat from req3 brings it to 0.
    bus.valid_up = 4'b1000;
    bus.data_up = {3'd6, 3'd7, 3'd7, 3'd7};
    cycle();
    bus.valid_up = 4'b0000;
    cycle();
    bus.valid_up = 4'hF;
    bus.data_up = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 6; i++) begin
      es = 2'(exp_src[i]);
      ed = 3'(exp_src[i] + 1);
      #1;
      n_checks++;
      if (bus.ready_up !== (4'b0001 << es)) begin
        n_errors++;
        $display("FAIL all_ready[%0d] got ru=%b want %b", i, bus.ready_up, 4'b0001 << es);
      end
      cycle();
      n_checks++;
      if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, ed, es}) begin
        n_errors++;
        $display("FAIL all_beat[%0d] got v=%b d=%0d s=%0d want v=1 d=%0d s=%0d",
                 i, bus.valid_down, bus.data_down, bus.src_id, ed, es);
      end
    end
    bus.valid_up = 4'b0000;
    cycle();
  endtask

  task automatic test_backpressure();
    // ptr is 2: req1 alone is found after wrapping.
    bus.valid_up = 4'b0010;
    bus.data_up = {3'd7, 3'd7, 3'd6, 3'd7};
    bus.ready_down = 1'b0;
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0010) begin
      n_errors++;
      $display("FAIL bp_load_ready got ru=%b want 0010", bus.ready_up);
    end
    cycle();
    bus.valid_up = 4'hF;
    bus.data_up = {3'd4, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus.ready_up !== 4'b0000) begin
        n_errors++;
        $display("FAIL bp_stall_ready[%0d] got ru=%b want 0000", i, bus.ready_up);
      end
      cycle();
      n_checks++;
      if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, 3'd6, 2'd1}) begin
        n_errors++;
        $display("FAIL bp_stall_slot[%0d] got v=%b d=%0d s=%0d want v=1 d=6 s=1",
                 i, bus.valid_down, bus.data_down, bus.src_id);
      end
    end
    bus.ready_down = 1'b1;
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0100) begin
      n_errors++;
      $display("FAIL bp_release_ready got ru=%b want 0100", bus.ready_up);
    end
    cycle();
    n_checks++;
    if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, 3'd3, 2'd2}) begin
      n_errors++;
      $display("FAIL bp_release_beat got v=%b d=%0d s=%0d want v=1 d=3 s=2",
               bus.valid_down, bus.data_down, bus.src_id);
    end
    bus.valid_up = 4'b0000;
    cycle();
  endtask

  task automatic test_wrap();
    // ptr is 3 with only req0/req1 valid.
    bus.valid_up = 4'b0011;
    bus.data_up = {3'd7, 3'd7, 3'd5, 3'd4};
    bus.ready_down = 1'b1;
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0001) begin
      n_errors++;
      $display("FAIL wrap_ready0 got ru=%b want 0001", bus.ready_up);
    end
    cycle();
    n_checks++;
    if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, 3'd4, 2'd0}) begin
      n_errors++;
      $display("FAIL wrap_beat0 got v=%b d=%0d s=%0d want v=1 d=4 s=0",
               bus.valid_down, bus.data_down, bus.src_id);
    end
    bus.valid_up = 4'b0010;
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0010) begin
      n_errors++;
      $display("FAIL wrap_ready1 got ru=%b want 0010", bus.ready_up);
    end
    cycle();
    n_checks++;
    if ({bus.valid_down, bus.data_down, bus.src_id} !== {1'b1, 3'd5, 2'd1}) begin
      n_errors++;
      $display("FAIL wrap_beat1 got v=%b d=%0d s=%0d want v=1 d=5 s=1",
               bus.valid_down, bus.data_down, bus.src_id);
    end
    bus.valid_up = 4'hF;
    bus.data_up = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    n_checks++;
    if (bus.ready_up !== 4'b0100) begin
      n_errors++;
      $display("FAIL wrap_ptr2 got ru=%b want 0100", bus.ready_up);
    end
    cycle();
    bus.valid_up = 4'b0000;
    cycle();
  endtask

  task automatic test_scoreboard();
    logic [NR-1:0] pend;
    logic [DW-1:0] pdata [NR];
    int unsigned   seq [NR];
    int unsigned   wait_n [NR];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_src;
    logic [1:0]    m_ptr;
    logic [1:0]    sel;
    logic [1:0]    idx;
    logic          any;
    logic          rd;
    logic [NR-1:0] exp_ru;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    pend = '0;
    m_valid = 1'b0;
    m_data = '0;
    m_src = '0;
    m_ptr = '0;
    for (int i = 0; i < NR; i++) begin
      pdata[i] = '0;
      seq[i] = 0;
      wait_n[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && c < 9980 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pdata[i] = 3'(seq[i]);
          seq[i]++;
          wait_n[i] = 0;
        end
      end
      rd = (c >= 9980) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.valid_up = pend;
      bus.data_up = {pdata[3], pdata[2], pdata[1], pdata[0]};
      bus.ready_down = rd;
      #1;
      n_checks++;
      if ({bus.valid_down, bus.data_down, bus.src_id} !== {m_valid, m_data, m_src}) begin
        n_errors++;
        $display("FAIL sb_slot c=%0d got v=%b d=%0d s=%0d want v=%b d=%0d s=%0d", c,
                 bus.valid_down, bus.data_down, bus.src_id, m_valid, m_data, m_src);
      end
      any = 1'b0;
      sel = '0;
      for (int k = 0; k < NR; k++) begin
        idx = m_ptr + 2'(k);
        if (!any && pend[idx]) begin
          any = 1'b1;
          sel = idx;
        end
      end
      exp_ru = (any && (!m_valid || rd)) ? (4'b0001 << sel) : 4'b0000;
      n_checks++;
      if (bus.ready_up !== exp_ru) begin
        n_errors++;
        $display("FAIL sb_ready c=%0d got ru=%b want %b", c, bus.ready_up, exp_ru);
      end
      if (m_valid && rd) begin
        n_checks++;
        if (sbq[m_src].size() == 0) begin
          n_errors++;
          $display("FAIL sb_order c=%0d got d=%0d from s=%0d want nothing outstanding",
                   c, bus.data_down, m_src);
        end else begin
          if (sbq[m_src][0] !== bus.data_down) begin
            n_errors++;
            $display("FAIL sb_order c=%0d got d=%0d want d=%0d s=%0d",
                     c, bus.data_down, sbq[m_src][0], m_src);
          end
          void'(sbq[m_src].pop_front());
        end
      end
      if (exp_ru != 4'b0000) begin
        n_checks++;
        if (wait_n[sel] > NR - 1) begin
          n_errors++;
          $display("FAIL sb_fair c=%0d got wait=%0d for s=%0d want <=%0d",
                   c, wait_n[sel], sel, NR - 1);
        end
        for (int i = 0; i < NR; i++) if (pend[i] && 2'(i) != sel) wait_n[i]++;
        sbq[sel].push_back(pdata[sel]);
        pend[sel] = 1'b0;
        m_valid = 1'b1;
        m_data = pdata[sel];
        m_src = sel;
        m_ptr = sel + 2'd1;
      end else if (rd) begin
        m_valid = 1'b0;
      end
      cycle();
    end
    for (int i = 0; i < NR; i++) begin
      n_checks++;
      if (sbq[i].size() != 0 || pend[i]) begin
        n_errors++;
        $display("FAIL sb_drain s=%0d got outstanding=%0d pending=%b want 0 0",
                 i, sbq[i].size(), pend[i]);
      end
    end
    bus.valid_up = 4'b0000;
  endtask

  initial begin
    bus.valid_up = '0;
    bus.data_up = '0;
    bus.ready_down = 1'b0;
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_wrap();
    test_scoreboard();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
